ff_bank: RTL and testbench

FF_BANK -- requirements
Module: ff_bank

---
 rtl/ff_bank.sv | 88 ++++++++
 tb/tb_ff_bank.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ff_bank.sv
// Bank of WIDTH flip-flop channels sharing one D/T/JK/SR mode select, with
// per-channel change flags, saturating change counters and a sticky SR-error flag.
module ff_bank #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      CNT_W     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  input  logic                   clr_cnt,
  output logic [WIDTH-1:0]       q,
  output logic [WIDTH-1:0]       qbar,
  output logic [WIDTH-1:0]       chg,
  output logic [WIDTH*CNT_W-1:0] tog_cnt,
  output logic                   sr_err
);

  localparam int unsigned CNT_TOT = WIDTH * CNT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [1:0] MODE_D  = 2'b00;
  localparam logic [1:0] MODE_T  = 2'b01;
  localparam logic [1:0] MODE_JK = 2'b10;

  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_chg;
  logic [CNT_TOT-1:0] r_cnt;
  logic               r_sr_err;

  logic [WIDTH-1:0]   w_q_nxt;
  logic [WIDTH-1:0]   w_chg;
  logic [CNT_TOT-1:0] w_cnt_nxt;
  logic               w_sr_set;

  // Next state for every channel; mode is used directly so it acts on the edge it is sampled.
  always_comb begin
    w_q_nxt = r_q;
    if (en) begin
      case (mode)
        MODE_D:  w_q_nxt = a;
        MODE_T:  w_q_nxt = r_q ^ a;
        MODE_JK: w_q_nxt = (a & ~r_q) | (~b & r_q);
        default: w_q_nxt = (a & ~b) | (r_q & ~(a ^ b));  // SR, 11 holds
      endcase
    end
  end

  assign w_chg    = w_q_nxt ^ r_q;
  assign w_sr_set = en && (mode == 2'b11) && (|(a & b));

  // Clear reloads with this edge's change so a same-edge toggle still counts once.
  always_comb begin
    w_cnt_nxt = r_cnt;
    for (int i = 0; i < WIDTH; i++) begin
      if (clr_cnt) begin
        w_cnt_nxt[i*CNT_W +: CNT_W] = CNT_W'(w_chg[i]);
      end else if (w_chg[i] && (r_cnt[i*CNT_W +: CNT_W] != CNT_MAX)) begin
        w_cnt_nxt[i*CNT_W +: CNT_W] = r_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q      <= RESET_VAL;
      r_chg    <= '0;
      r_cnt    <= '0;
      r_sr_err <= 1'b0;
    end else begin
      r_q      <= w_q_nxt;
      r_chg    <= w_chg;
      r_cnt    <= w_cnt_nxt;
      r_sr_err <= w_sr_set | (r_sr_err & ~clr_cnt);
    end
  end

  // qbar derives from the same register as q so the two can never skew.
  assign q       = r_q;
  assign qbar    = ~r_q;
  assign chg     = r_chg;
  assign tog_cnt = r_cnt;
  assign sr_err  = r_sr_err;

endmodule

// File: tb/tb_ff_bank.sv
// Directed plus randomized checking of ff_bank against a per-channel behavioural model.
module tb_ff_bank;

  localparam int unsigned W   = 8;
  localparam int unsigned CW  = 4;
  localparam logic [W-1:0] RV = 8'h96;
  localparam int CMAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst, en, clr_cnt;
  logic [1:0]      mode;
  logic [W-1:0]    a, b;
  logic [W-1:0]    q, qbar, chg;
  logic [W*CW-1:0] tog_cnt;
  logic            sr_err;

  ff_bank #(.WIDTH(W), .CNT_W(CW), .RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .clr_cnt(clr_cnt),
    .q(q), .qbar(qbar), .chg(chg), .tog_cnt(tog_cnt), .sr_err(sr_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  string tag = "init";

  // Reference state, one entry per channel.
  int m_q   [W];
  int m_chg [W];
  int m_cnt [W];
  int m_err;

  function automatic void model_edge();
    int nq;
    int any_bad;
    if (rst) begin
      for (int i = 0; i < W; i++) begin
        m_q[i] = int'(RV[i]); m_chg[i] = 0; m_cnt[i] = 0;
      end
      m_err = 0;
      return;
    end
    any_bad = 0;
    for (int i = 0; i < W; i++) begin
      int ai = int'(a[i]);
      int bi = int'(b[i]);
      nq = m_q[i];
      if (en) begin
        case (mode)
          2'b00: nq = ai;
          2'b01: nq = (ai == 1) ? 1 - m_q[i] : m_q[i];
          2'b10: begin
            if (ai == 0 && bi == 1) nq = 0;
            else if (ai == 1 && bi == 0) nq = 1;
            else if (ai == 1 && bi == 1) nq = 1 - m_q[i];
          end
          default: begin
            if (ai == 0 && bi == 1) nq = 0;
            else if (ai == 1 && bi == 0) nq = 1;
            if (ai == 1 && bi == 1) any_bad = 1;
          end
        endcase
      end
      m_chg[i] = (en && nq != m_q[i]) ? 1 : 0;
      m_q[i] = nq;
      if (clr_cnt) m_cnt[i] = m_chg[i];
      else if (m_chg[i] == 1 && m_cnt[i] < CMAX) m_cnt[i] = m_cnt[i] + 1;
    end
    if (any_bad == 1) m_err = 1;
    else if (clr_cnt) m_err = 0;
  endfunction

  task automatic check_all();
    logic [W-1:0] eq, ec;
    logic [CW-1:0] got_c, exp_c;
    for (int i = 0; i < W; i++) begin
      eq[i] = m_q[i][0];
      ec[i] = m_chg[i][0];
    end
    checks++;
    assert (q === eq) else begin
      failures++; $error("FAIL %s q got=%h exp=%h", tag, q, eq);
    end
    checks++;
    assert (qbar === ~eq) else begin
      failures++; $error("FAIL %s qbar got=%h exp=%h", tag, qbar, ~eq);
    end
    checks++;
    assert (chg === ec) else begin
      failures++; $error("FAIL %s chg got=%h exp=%h", tag, chg, ec);
    end
    checks++;
    assert (sr_err === m_err[0]) else begin
      failures++; $error("FAIL %s sr_err got=%b exp=%0d", tag, sr_err, m_err);
    end
    for (int i = 0; i < W; i++) begin
      got_c = tog_cnt[i*CW +: CW];
      exp_c = CW'(m_cnt[i]);
      checks++;
      assert (got_c === exp_c) else begin
        failures++; $error("FAIL %s cnt[%0d] got=%0d exp=%0d", tag, i, got_c, exp_c);
      end
    end
  endtask

  task automatic step(input string t, input logic r, input logic e, input logic [1:0] m,
                      input logic [W-1:0] ia, input logic [W-1:0] ib, input logic c);
    @(negedge clk);
    tag = t; rst = r; en = e; mode = m; a = ia; b = ib; clr_cnt = c;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    for (int i = 0; i < W; i++) begin
      m_q[i] = 0; m_chg[i] = 0; m_cnt[i] = 0;
    end
    m_err = 0;
    rst = 1'b1; en = 1'b1; clr_cnt = 1'b1; mode = 2'b11; a = '1; b = '1;

    // Reset overrides enable, clear and an SR error request.
    step("reset", 1'b1, 1'b1, 2'b11, 8'hFF, 8'hFF, 1'b1);
    step("reset2", 1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
    step("d_a5_pre", 1'b0, 1'b1, 2'b00, 8'h00, 8'h00, 1'b1);
    step("rst_a5", 1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
    step("d_a5", 1'b0, 1'b1, 2'b00, 8'hA5, 8'h00, 1'b0);

    // T mode counting to saturation from q=00.
    step("d_zero", 1'b0, 1'b1, 2'b00, 8'h00, 8'h00, 1'b0);
    step("clr", 1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 1'b1);
    for (int k = 0; k < 20; k++) step("t_sat", 1'b0, 1'b1, 2'b01, 8'h01, 8'h00, 1'b0);

    // JK from F0 covers hold/clear/set/toggle on each bit pair.
    step("d_f0", 1'b0, 1'b1, 2'b00, 8'hF0, 8'h00, 1'b0);
    step("jk", 1'b0, 1'b1, 2'b10, 8'hCC, 8'hAA, 1'b0);
    checks++;
    assert (q === 8'h5C) else begin
      failures++; $error("FAIL jk_const q got=%h exp=5c", q);
    end

    // SR forbidden input, clear, and set-beats-clear.
    step("sr_bad", 1'b0, 1'b1, 2'b11, 8'h01, 8'h01, 1'b0);
    step("sr_clr", 1'b0, 1'b1, 2'b11, 8'h00, 8'h00, 1'b1);
    step("sr_bad2", 1'b0, 1'b1, 2'b11, 8'h01, 8'h01, 1'b1);
    step("sr_set", 1'b0, 1'b1, 2'b11, 8'h0F, 8'h30, 1'b0);
    step("clr_noen", 1'b0, 1'b0, 2'b11, 8'h00, 8'h00, 1'b1);

    // Disabled D writes hold q and counters, zero chg; then reset with enable high.
    step("d_load", 1'b0, 1'b1, 2'b00, 8'h3A, 8'h00, 1'b0);
    for (int k = 0; k < 3; k++) step("en0", 1'b0, 1'b0, 2'b00, 8'hFF, 8'h00, 1'b0);
    step("rst_en", 1'b1, 1'b1, 2'b00, 8'hFF, 8'h00, 1'b0);
    step("post_rst_t", 1'b0, 1'b1, 2'b01, 8'h0F, 8'h00, 1'b0);

    // Random traffic with occasional mid-operation reset and clear.
    for (int k = 0; k < 400; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      step("rand", ($urandom_range(0, 39) == 0), ($urandom_range(0, 4) != 0),
           2'($urandom), ra, rb, ($urandom_range(0, 9) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
